// File: rtl/rfsoc_config.sv
// Shared configuration for the rfsoc DAC playback path:
// gpio_ctrl bit map, bus widths and the playback FSM state type.
package rfsoc_config;

  localparam int unsigned GPIO_W = 16;
  localparam int unsigned WORD_W = 128;

  localparam int unsigned trigger_line = 0;
  localparam int unsigned dac_load     = 1;
  localparam int unsigned dac_flush    = 2;
  localparam int unsigned dac_loop     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2,
    PLAY  = 2'd3
  } dac_state_t;

endpackage

// File: rtl/dac_sample_ram.sv
// Simple dual-port sample buffer: one write port and one
// registered read port with 1-cycle latency. Contents never reset.
module dac_sample_ram
  import rfsoc_config::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = WORD_W
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/dac_playback.sv
// Triggered DAC waveform playback from an on-chip sample buffer.
// Define DAC_LOOP_EN to honour gpio_ctrl[dac_loop] (continuous replay).
module dac_playback
  import rfsoc_config::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                pl_clk,
  input  logic                rst,
  input  logic [GPIO_W-1:0]   gpio_ctrl,
  input  logic [WORD_W-1:0]   s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [WORD_W-1:0]   m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [ADDR_W+2:0]   status
);

  dac_state_t        r_state;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W-1:0] r_raddr;
  logic              r_trig_q;
  logic              r_trig_edge;
  logic              r_load_q;
  logic              r_rd_vld;
  logic              r_tvalid;
  logic [WORD_W-1:0] r_tdata;

  logic              w_trig;
  logic              w_load;
  logic              w_flush;
  logic              w_loop;
  logic              w_full;
  logic              w_wr;
  logic              w_abort;
  logic              w_start;
  logic              w_rd;
  logic              w_last;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_last_addr;
  logic [WORD_W-1:0] w_rd_data;
  logic              w_unused;

  assign w_trig  = gpio_ctrl[trigger_line];
  assign w_load  = gpio_ctrl[dac_load];
  assign w_flush = gpio_ctrl[dac_flush];

`ifdef DAC_LOOP_EN
  assign w_loop = gpio_ctrl[dac_loop];
`else
  assign w_loop = 1'b0;
`endif

  // DAC consumes every cycle, so downstream ready carries no information
  assign w_unused = ^{m_axis_tready, gpio_ctrl};

  assign w_full = r_count[ADDR_W];

  assign s_axis_tready = (r_state == LOAD) && !w_full
                       && !w_flush && !rst;

  assign w_wr = s_axis_tvalid && s_axis_tready;

  assign w_abort = w_load && !r_load_q
                 && (r_state == ARMED || r_state == PLAY);

  assign w_start = (r_state == ARMED) && r_trig_edge
                 && !w_flush && !w_abort && !rst;

  assign w_rd = w_start
              || ((r_state == PLAY) && !w_flush
                  && !w_abort && !rst);

  assign w_rd_addr = w_start ? '0 : r_raddr;

  // A full buffer has zero low count bits; minus one wraps to DEPTH-1
  assign w_last_addr = r_count[ADDR_W-1:0] - ADDR_W'(1);
  assign w_last      = (w_rd_addr == w_last_addr);

  dac_sample_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (WORD_W)
  ) u_ram (
    .clk     (pl_clk),
    .i_we    (w_wr),
    .i_waddr (r_count[ADDR_W-1:0]),
    .i_wdata (s_axis_tdata),
    .i_re    (w_rd),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge pl_clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_raddr     <= '0;
      r_trig_q    <= 1'b0;
      r_trig_edge <= 1'b0;
      r_load_q    <= 1'b0;
      r_rd_vld    <= 1'b0;
      r_tvalid    <= 1'b0;
      r_tdata     <= '0;
    end else begin
      r_trig_q    <= w_trig;
      r_trig_edge <= w_trig && !r_trig_q
                   && (r_state == ARMED);
      r_load_q    <= w_load;
      r_tvalid    <= 1'b1;
      r_rd_vld    <= w_rd;
      r_tdata     <= r_rd_vld ? w_rd_data : '0;
      if (w_flush) begin
        r_state  <= IDLE;
        r_count  <= '0;
        r_rd_vld <= 1'b0;
        r_tdata  <= '0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (w_load) begin
              r_state <= LOAD;
              r_count <= '0;
            end
          end
          LOAD: begin
            if (w_wr) r_count <= r_count + (ADDR_W+1)'(1);
            if (!w_load) begin
              r_state <= (r_count != '0 || w_wr) ? ARMED : IDLE;
            end
          end
          ARMED, PLAY: begin
            if (w_abort) begin
              r_state  <= LOAD;
              r_count  <= '0;
              r_rd_vld <= 1'b0;
              r_tdata  <= '0;
            end else if (w_rd) begin
              r_raddr <= w_last ? '0 : w_rd_addr + ADDR_W'(1);
              r_state <= (w_last && !w_loop) ? ARMED : PLAY;
            end
          end
        endcase
      end
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;

  assign status = {r_state == PLAY, r_state == ARMED,
                   w_full, r_count[ADDR_W-1:0]};

endmodule

// File: tb/tb_dac_playback.sv
// Directed bench for dac_playback with an 8-word buffer.
// Expected words are rebuilt from the same generator used to load them.
module tb_dac_playback;
  import rfsoc_config::*;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic              pl_clk = 1'b0;
  logic              rst;
  logic [15:0]       gpio_ctrl;
  logic [127:0]      s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [127:0]      m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [AW+2:0]     status;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 pl_clk = ~pl_clk;

  dac_playback #(.ADDR_W(AW)) dut (
    .pl_clk        (pl_clk),
    .rst           (rst),
    .gpio_ctrl     (gpio_ctrl),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .status        (status)
  );

  task automatic tick;
    @(posedge pl_clk);
    #1;
  endtask

  function automatic logic [127:0] mkw(input int i);
    logic [15:0] s;
    s = 16'hA000 + 16'(i);
    return {8{s}};
  endfunction

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic load_words(input int n, input int base);
    gpio_ctrl[dac_load] = 1'b1;
    tick;
    for (int i = 0; i < n; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = mkw(base + i);
      tick;
    end
    s_axis_tvalid = 1'b0;
    gpio_ctrl[dac_load] = 1'b0;
    tick;
  endtask

  // trigger in cycle 0; words expected in cycles 3 .. 3+nw-1
  task automatic play_run(input string tag, input int ncyc,
                          input int retrig, input int nw,
                          input int base);
    logic [127:0] exp;
    for (int c = 0; c < ncyc; c++) begin
      exp = (c >= 3 && c < 3 + nw) ? mkw(base + c - 3) : '0;
      check($sformatf("%s_c%0d", tag, c), m_axis_tdata, exp);
      gpio_ctrl[trigger_line] = (c == 0 || c == retrig);
      tick;
    end
    gpio_ctrl[trigger_line] = 1'b0;
  endtask

  initial begin
    int acc;
    logic [127:0] exp;
    rst           = 1'b1;
    gpio_ctrl     = '0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    tick;
    tick;
    check("rst_tdata", m_axis_tdata, '0);
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tready", s_axis_tready, 1'b0);
    check("rst_status", status, '0);
    rst = 1'b0;
    tick;
    check("tvalid_up", m_axis_tvalid, 1'b1);
    check("idle_tready", s_axis_tready, 1'b0);

    load_words(4, 0);
    check("armed_status", status, 6'b010100);
    check("armed_tready", s_axis_tready, 1'b0);
    play_run("play4", 10, -1, 4, 0);
    check("replay_armed", status, 6'b010100);

    play_run("retrig", 12, 3, 4, 0);
    play_run("again", 10, -1, 4, 0);

    gpio_ctrl[trigger_line] = 1'b1;
    gpio_ctrl[dac_flush]    = 1'b1;
    tick;
    gpio_ctrl[trigger_line] = 1'b0;
    gpio_ctrl[dac_flush]    = 1'b0;
    check("flush_status", status, '0);
    check("flush_tdata", m_axis_tdata, '0);
    play_run("idle_trig", 8, -1, 0, 0);

    gpio_ctrl[dac_load] = 1'b1;
    tick;
    acc = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = mkw(16 + i);
      #1;
      if (s_axis_tready) acc++;
      tick;
    end
    check("full_beats", 128'(acc), 128'(DEPTH));
    check("full_tready", s_axis_tready, 1'b0);
    check("full_status", status, 6'b001000);
    s_axis_tvalid = 1'b0;
    gpio_ctrl[dac_load] = 1'b0;
    tick;
    check("full_armed", status, 6'b011000);
    play_run("play8", 12, -1, DEPTH, 16);

    load_words(4, 32);
    for (int c = 0; c < 8; c++) begin
      exp = (c == 3) ? mkw(32) : ((c == 4) ? mkw(33) : '0);
      check($sformatf("abort_c%0d", c), m_axis_tdata, exp);
      gpio_ctrl[trigger_line] = (c == 0);
      gpio_ctrl[dac_load]     = (c >= 4);
      tick;
    end
    check("abort_status", status, '0);
    gpio_ctrl[dac_load] = 1'b0;
    tick;
    check("abort_idle", status, '0);
    check("abort_tready", s_axis_tready, 1'b0);

    load_words(4, 48);
    for (int c = 0; c < 5; c++) begin
      exp = (c >= 3) ? mkw(48 + c - 3) : '0;
      check($sformatf("prerst_c%0d", c), m_axis_tdata, exp);
      gpio_ctrl[trigger_line] = (c == 0);
      tick;
    end
    rst = 1'b1;
    tick;
    check("mrst_tdata", m_axis_tdata, '0);
    check("mrst_tvalid", m_axis_tvalid, 1'b0);
    check("mrst_tready", s_axis_tready, 1'b0);
    check("mrst_status", status, '0);
    rst = 1'b0;
    tick;
    check("mrst_tvalid_up", m_axis_tvalid, 1'b1);
    play_run("postrst", 8, -1, 0, 0);
    check("postrst_status", status, '0);

    load_words(3, 64);
    gpio_ctrl[dac_loop] = 1'b1;
`ifdef DAC_LOOP_EN
    for (int c = 0; c < 14; c++) begin
      exp = (c >= 3 && c <= 11) ? mkw(64 + (c - 3) % 3) : '0;
      check($sformatf("loop_c%0d", c), m_axis_tdata, exp);
      gpio_ctrl[trigger_line] = (c == 0);
      if (c == 7) gpio_ctrl[dac_loop] = 1'b0;
      tick;
    end
`else
    play_run("noloop", 10, -1, 3, 64);
`endif
    gpio_ctrl[dac_loop] = 1'b0;
    check("loop_end_armed", status, 6'b010011);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_playback.md
DAC_PLAYBACK -- requirements
Module: dac_playback

Interface
REQ-001 Parameter: ADDR_W, default 10, log2 of sample-buffer depth in 128-bit words (DEPTH = 2**ADDR_W).
REQ-002 Port: pl_clk  input  1  sole clock; all logic on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: gpio_ctrl  input  16  control word from the rfsoc control block; bit indices trigger_line, dac_load, dac_flush.
REQ-005 Port: s_axis_tdata / s_axis_tvalid / s_axis_tready  in/in/out  128/1/1  waveform words from the PS path, already in pl_clk domain.
REQ-006 Port: m_axis_tdata / m_axis_tvalid  out/out  128/1  sample words to the DAC, 8 x 16-bit samples, sample 0 in bits [15:0].
REQ-007 Port: m_axis_tready  input  1  ignored; the DAC consumes every cycle.
REQ-008 Port: status  output  ADDR_W+3  {playing, armed, full, loaded_words[ADDR_W-1:0]}.

Function
REQ-009 The FSM SHALL have states IDLE, LOAD, ARMED, PLAY.
REQ-010 IDLE->LOAD when dac_load=1; LOAD clears loaded_words on entry.
REQ-011 In LOAD, s_axis_tready SHALL be 1 while loaded_words<DEPTH; each tvalid&tready beat writes RAM[loaded_words] and increments loaded_words.
REQ-012 At loaded_words=DEPTH, full=1 and s_axis_tready=0; further beats stall without loss or overwrite.
REQ-013 LOAD->ARMED when dac_load falls with loaded_words>0; LOAD->IDLE when it falls with loaded_words=0.
REQ-014 Outside LOAD, s_axis_tready SHALL be 0.
REQ-015 A trigger is the rising edge of gpio_ctrl[trigger_line], detected against a 1-cycle registered copy.
REQ-016 ARMED->PLAY on a trigger; triggers in IDLE, LOAD or PLAY are ignored.
REQ-017 In PLAY, the read address runs 0..loaded_words-1, one word per cycle; the first word appears on m_axis_tdata exactly 3 cycles after the trigger-edge cycle (edge register, RAM read, output register).
REQ-018 After the last word is read, PLAY->ARMED; the buffer is retained, so re-triggering replays identical data.
REQ-019 m_axis_tdata SHALL be 0 whenever no buffer word is being presented.
REQ-020 m_axis_tvalid SHALL be 1 in every cycle except during reset.
REQ-021 dac_flush=1 in any state SHALL force IDLE, loaded_words=0 and m_axis_tdata=0 on the next cycle; flush wins over a simultaneous trigger or load beat.
REQ-022 dac_load rising while in ARMED or PLAY SHALL abort playback, output 0, and enter LOAD.

Reset
REQ-023 rst SHALL force IDLE, loaded_words=0, trigger register=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, status=0; RAM contents are not cleared.
REQ-024 rst asserted mid-LOAD or mid-PLAY SHALL discard the operation; after release the block behaves as freshly reset.

Configuration
REQ-025 With macro DAC_LOOP_EN defined, gpio_ctrl[dac_loop] SHALL be honoured: when it is 1, PLAY wraps from loaded_words-1 to address 0 with no gap cycle, and returns to ARMED at the end of the current pass once it is 0.
REQ-026 Without DAC_LOOP_EN, playback SHALL always be one-shot and gpio_ctrl[dac_loop] SHALL be ignored.

Structure
REQ-027 Bit indices trigger_line, dac_load, dac_flush and dac_loop, and the FSM state enum, SHALL live in package rfsoc_config.
REQ-028 Buffer storage SHALL be sub-module dac_sample_ram: simple dual-port, one write port and one registered read port, 1-cycle read latency, DEPTH x 128.

Verification
REQ-029 Load 4 words A0..A3 with dac_load held, drop dac_load, then trigger -> m_axis_tdata = A0,A1,A2,A3 on cycles T+3..T+6, then 0; status.armed=1.
REQ-030 Load DEPTH+2 beats with tvalid held high -> exactly DEPTH beats accepted, s_axis_tready=0 afterward, full=1.
REQ-031 Apply trigger and dac_flush in the same cycle while ARMED -> IDLE, output stays 0, loaded_words=0.
REQ-032 Trigger again 2 cycles into a 4-word PLAY -> no restart; the sequence completes once, then a new trigger replays A0..A3.
REQ-033 With DAC_LOOP_EN and dac_loop=1, play 3 words -> A0,A1,A2,A0,A1,... with no gaps; clearing dac_loop ends after the current A2.
REQ-034 Assert rst mid-PLAY -> next cycle all outputs 0 and state IDLE; a trigger afterward produces no output.
